block_table: RTL and testbench

- Parametrised, writable successor to the fixed brick-position lookup.
- Holds DEPTH brick entries of {alive, x, y}. A load FSM builds a staggered brick layout one entry per cycle, with the layout's vertical position chosen per level.
- Collision logic clears individual bricks.
- Exposes a registered read port for the renderer/collision scanner, a live brick count and an all-cleared flag for the game-control FSM.

---
 rtl/breakout_pkg.sv | 29 ++
 rtl/block_layout_gen.sv | 98 +++++++++
 rtl/block_table.sv | 140 ++++++++++++++
 tb/tb_block_table.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared definitions for the brick table: field widths, entry layout,
// controller state encoding and default layout geometry.
package breakout_pkg;

    localparam int DEF_X_W      = 10;
    localparam int DEF_Y_W      = 9;
    localparam int DEF_X0       = 100;
    localparam int DEF_PITCH    = 90;
    localparam int DEF_Y0       = 320;
    localparam int DEF_ROW_H    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Packed entry is {alive, x, y}, alive in the MSB.
    function automatic int entry_w(input int xw, input int yw);
        return 1 + xw + yw;
    endfunction

    typedef struct packed {
        logic               alive;
        logic [DEF_X_W-1:0] x;
        logic [DEF_Y_W-1:0] y;
    } entry_t;

endpackage

// File: rtl/block_layout_gen.sv
// Walks the staggered brick layout one entry per cycle using only adders and
// counters, emitting a write for every table index from 0 to DEPTH-1.
module block_layout_gen
    import breakout_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int LVL_W    = 3,
    parameter int ROWS     = 3,
    parameter int COLS0    = 6,
    parameter int X0       = DEF_X0,
    parameter int PITCH    = DEF_PITCH,
    parameter int Y0       = DEF_Y0,
    parameter int ROW_H    = DEF_ROW_H,
    parameter int LEVEL_DY = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int EW      = entry_w(X_W, Y_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LVL_W-1:0] level,
    output logic             wr_en,
    output logic [AW-1:0]    wr_idx,
    output logic [EW-1:0]    wr_data,
    output logic             wr_last
);

    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS0 + 1);

    localparam logic [X_W-1:0] PITCH_X = X_W'(PITCH);
    localparam logic [X_W-1:0] HALF_X  = X_W'(PITCH / 2);
    localparam logic [Y_W-1:0] ROW_H_Y = Y_W'(ROW_H);

    logic          active_reg;
    logic [AW-1:0] idx_reg;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [X_W-1:0] x_acc_reg;
    logic [X_W-1:0] row_x_reg;
    logic [Y_W-1:0] y_acc_reg;

    logic [Y_W-1:0] y_base;
    logic           in_layout;
    logic           row_last;
    logic           idx_last;

    // The level multiply happens once at load time, never inside the build loop.
    assign y_base    = Y_W'(Y0) + Y_W'(level * LEVEL_DY);
    assign in_layout = row_reg < RW'(ROWS);
    assign row_last  = col_reg == (CW'(COLS0 - 1) - CW'(row_reg));
    assign idx_last  = idx_reg == AW'(DEPTH - 1);

    assign wr_en   = active_reg;
    assign wr_idx  = idx_reg;
    assign wr_data = in_layout ? {1'b1, x_acc_reg, y_acc_reg} : '0;
    assign wr_last = active_reg && idx_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg <= 1'b0;
            idx_reg    <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            x_acc_reg  <= '0;
            row_x_reg  <= '0;
            y_acc_reg  <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            idx_reg    <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            x_acc_reg  <= X_W'(X0);
            row_x_reg  <= X_W'(X0);
            y_acc_reg  <= y_base;
        end else if (active_reg) begin
            idx_reg <= idx_reg + AW'(1);
            if (idx_last)
                active_reg <= 1'b0;
            if (in_layout) begin
                if (row_last) begin
                    // Next row starts half a pitch right of the previous row start.
                    row_reg   <= row_reg + RW'(1);
                    col_reg   <= '0;
                    row_x_reg <= row_x_reg + HALF_X;
                    x_acc_reg <= row_x_reg + HALF_X;
                    y_acc_reg <= y_acc_reg + ROW_H_Y;
                end else begin
                    col_reg   <= col_reg + CW'(1);
                    x_acc_reg <= x_acc_reg + PITCH_X;
                end
            end
        end
    end

endmodule

// File: rtl/block_table.sv
// Writable brick table: layout load FSM, per-brick hit clearing, registered
// read port, live brick count and all-cleared flag.
module block_table
    import breakout_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int LVL_W    = 3,
    parameter int ROWS     = 3,
    parameter int COLS0    = 6,
    parameter int X0       = DEF_X0,
    parameter int PITCH    = DEF_PITCH,
    parameter int Y0       = DEF_Y0,
    parameter int ROW_H    = DEF_ROW_H,
    parameter int LEVEL_DY = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int CNTW    = $clog2(DEPTH + 1),
    localparam int EW      = entry_w(X_W, Y_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LVL_W-1:0] level,
    input  logic [AW-1:0]    addr,
    output logic [EW-1:0]    q,
    input  logic             hit_valid,
    input  logic [AW-1:0]    hit_addr,
    output logic             busy,
    output logic [CNTW-1:0]  alive_count,
    output logic             cleared
);

    if (ROWS * COLS0 - ROWS * (ROWS - 1) / 2 > DEPTH) begin : g_chk_depth
        $error("block_table: brick layout does not fit in DEPTH entries");
    end
    if (COLS0 < ROWS) begin : g_chk_cols
        $error("block_table: COLS0 must be at least ROWS");
    end

    state_t          state_reg;
    logic [EW-1:0]   q_reg;
    logic            busy_reg;
    logic [CNTW-1:0] alive_count_reg;
    logic            cleared_reg;

    // Coordinates live in the array; alive bits are flops so hits can test them.
    logic [X_W+Y_W-1:0] coord_mem [DEPTH];
    logic [DEPTH-1:0]   alive_reg;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [EW-1:0]   wr_data;
    logic            wr_last;
    logic            load_accept;
    logic            hit_clr;

    assign load_accept = load && (state_reg != ST_LOAD);
    assign hit_clr     = (state_reg == ST_READY) && !load && hit_valid && alive_reg[hit_addr];

    block_layout_gen #(
        .DEPTH    (DEPTH),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .LVL_W    (LVL_W),
        .ROWS     (ROWS),
        .COLS0    (COLS0),
        .X0       (X0),
        .PITCH    (PITCH),
        .Y0       (Y0),
        .ROW_H    (ROW_H),
        .LEVEL_DY (LEVEL_DY)
    ) u_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (load_accept),
        .level   (level),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_last (wr_last)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_alive
        always_ff @(posedge clk) begin
            if (rst)
                alive_reg[gi] <= 1'b0;
            else if (wr_en && wr_idx == AW'(gi))
                alive_reg[gi] <= wr_data[EW-1];
            else if (hit_clr && hit_addr == AW'(gi))
                alive_reg[gi] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            q_reg           <= '0;
            busy_reg        <= 1'b0;
            alive_count_reg <= '0;
            cleared_reg     <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                coord_mem[i] <= '0;
        end else begin
            q_reg       <= {alive_reg[addr], coord_mem[addr]};
            cleared_reg <= (state_reg == ST_READY) && !load && (alive_count_reg == '0);
            if (wr_en)
                coord_mem[wr_idx] <= wr_data[X_W+Y_W-1:0];
            case (state_reg)
                ST_IDLE, ST_READY: begin
                    if (load_accept) begin
                        state_reg       <= ST_LOAD;
                        busy_reg        <= 1'b1;
                        alive_count_reg <= '0;
                    end else if (hit_clr) begin
                        alive_count_reg <= alive_count_reg - CNTW'(1);
                    end
                end
                ST_LOAD: begin
                    if (wr_en && wr_data[EW-1])
                        alive_count_reg <= alive_count_reg + CNTW'(1);
                    if (wr_last) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q           = q_reg;
    assign busy        = busy_reg;
    assign alive_count = alive_count_reg;
    assign cleared     = cleared_reg;

endmodule

// File: tb/tb_block_table.sv
// Directed bench for block_table at default parameters: layout contents,
// level offset, hit clearing, cleared flag, load/hit priority, mid-load reset.
module tb_block_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [2:0]  level;
    logic [3:0]  addr;
    logic [19:0] q;
    logic        hit_valid;
    logic [3:0]  hit_addr;
    logic        busy;
    logic [4:0]  alive_count;
    logic        cleared;

    int tests_run = 0;
    int tests_failed = 0;

    block_table dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .level       (level),
        .addr        (addr),
        .q           (q),
        .hit_valid   (hit_valid),
        .hit_addr    (hit_addr),
        .busy        (busy),
        .alive_count (alive_count),
        .cleared     (cleared)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ent(input bit al, input int x, input int y);
        logic [9:0] xv;
        logic [8:0] yv;
        xv = 10'(x);
        yv = 9'(y);
        return {al, xv, yv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_q(input logic [3:0] a, output logic [19:0] v);
        addr = a;
        step();
        v = q;
        $display("[TB] read addr=%0d q={%0d,%0d,%0d}", a, v[19], v[18:9], v[8:0]);
    endtask

    task automatic start_load(input logic [2:0] lvl);
        level = lvl;
        load  = 1'b1;
        step();
        load  = 1'b0;
        $display("[TB] load level=%0d busy=%0d", lvl, busy);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        logic [19:0] v;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || alive_count !== 5'd0 || cleared !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy=%0d count=%0d cleared=%0d, need 0/0/0", busy, alive_count, cleared);
        end
        read_q(4'd5, v);
        tests_run++;
        if (v !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_q: q=%h need 0", v);
        end
    endtask

    task automatic test_load_level0();
        int n;
        logic [19:0] v;
        logic [3:0]  adrs [5] = '{4'd0, 4'd5, 4'd6, 4'd14, 4'd15};
        logic [19:0] exps [5];
        exps[0] = ent(1, 100, 320);
        exps[1] = ent(1, 550, 320);
        exps[2] = ent(1, 145, 330);
        exps[3] = ent(1, 460, 340);
        exps[4] = ent(0, 0, 0);
        start_load(3'd0);
        wait_ready(n);
        tests_run++;
        if (n != 16) begin
            tests_failed++;
            $display("FAIL load0_busy_cycles: got %0d need 16", n);
        end
        for (int i = 0; i < 5; i++) begin
            read_q(adrs[i], v);
            tests_run++;
            if (v !== exps[i]) begin
                tests_failed++;
                $display("FAIL load0_entry%0d: q=%h need %h", adrs[i], v, exps[i]);
            end
        end
        tests_run++;
        if (alive_count !== 5'd15 || cleared !== 1'b0) begin
            tests_failed++;
            $display("FAIL load0_count: count=%0d cleared=%0d need 15/0", alive_count, cleared);
        end
    endtask

    task automatic test_level2();
        int n;
        logic [19:0] v;
        start_load(3'd2);
        wait_ready(n);
        read_q(4'd0, v);
        tests_run++;
        if (v !== ent(1, 100, 336)) begin
            tests_failed++;
            $display("FAIL level2_entry0: q=%h need %h", v, ent(1, 100, 336));
        end
        read_q(4'd11, v);
        tests_run++;
        if (v !== ent(1, 190, 356)) begin
            tests_failed++;
            $display("FAIL level2_entry11: q=%h need %h", v, ent(1, 190, 356));
        end
    endtask

    task automatic test_hit();
        int n;
        logic [19:0] v;
        start_load(3'd0);
        wait_ready(n);
        hit_addr  = 4'd3;
        hit_valid = 1'b1;
        step();
        hit_valid = 1'b0;
        $display("[TB] hit addr=3 count=%0d", alive_count);
        tests_run++;
        if (alive_count !== 5'd14) begin
            tests_failed++;
            $display("FAIL hit_first: count=%0d need 14", alive_count);
        end
        hit_valid = 1'b1;
        step();
        hit_valid = 1'b0;
        $display("[TB] hit addr=3 count=%0d", alive_count);
        tests_run++;
        if (alive_count !== 5'd14) begin
            tests_failed++;
            $display("FAIL hit_dead: count=%0d need 14", alive_count);
        end
        read_q(4'd3, v);
        tests_run++;
        if (v !== ent(0, 370, 320)) begin
            tests_failed++;
            $display("FAIL hit_entry3: q=%h need %h", v, ent(0, 370, 320));
        end
    endtask

    task automatic test_clear_all();
        int n;
        for (int a = 0; a < 15; a++) begin
            hit_addr  = 4'(a);
            hit_valid = 1'b1;
            step();
            $display("[TB] hit addr=%0d count=%0d", a, alive_count);
        end
        hit_valid = 1'b0;
        tests_run++;
        if (alive_count !== 5'd0 || cleared !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_count: count=%0d cleared=%0d need 0/0", alive_count, cleared);
        end
        step();
        tests_run++;
        if (cleared !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_flag: cleared=%0d need 1", cleared);
        end
        start_load(3'd0);
        tests_run++;
        if (cleared !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_reload: cleared=%0d busy=%0d need 0/1", cleared, busy);
        end
        wait_ready(n);
        tests_run++;
        if (n != 16 || alive_count !== 5'd15) begin
            tests_failed++;
            $display("FAIL clear_reload_done: cycles=%0d count=%0d need 16/15", n, alive_count);
        end
    endtask

    task automatic test_hit_vs_load();
        int n;
        logic [19:0] v;
        hit_addr  = 4'd0;
        hit_valid = 1'b1;
        level     = 3'd0;
        load      = 1'b1;
        step();
        load      = 1'b0;
        hit_valid = 1'b0;
        $display("[TB] load+hit addr=0 count=%0d busy=%0d", alive_count, busy);
        tests_run++;
        if (alive_count !== 5'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL hitload_accept: count=%0d busy=%0d need 0/1", alive_count, busy);
        end
        wait_ready(n);
        read_q(4'd0, v);
        tests_run++;
        if (v[19] !== 1'b1 || alive_count !== 5'd15) begin
            tests_failed++;
            $display("FAIL hitload_after: alive=%0d count=%0d need 1/15", v[19], alive_count);
        end
    endtask

    task automatic test_rst_mid_load();
        int n;
        int bad;
        logic [19:0] v;
        start_load(3'd1);
        repeat (6) step();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_busy_before: busy=%0d need 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("[TB] reset mid-load busy=%0d count=%0d", busy, alive_count);
        tests_run++;
        if (busy !== 1'b0 || alive_count !== 5'd0 || cleared !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flags: busy=%0d count=%0d cleared=%0d need 0/0/0", busy, alive_count, cleared);
        end
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            read_q(4'(a), v);
            if (v !== 20'd0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL midrst_table: %0d nonzero entries, need 0", bad);
        end
        start_load(3'd0);
        wait_ready(n);
        read_q(4'd14, v);
        tests_run++;
        if (n != 16 || alive_count !== 5'd15 || v !== ent(1, 460, 340)) begin
            tests_failed++;
            $display("FAIL midrst_reload: cycles=%0d count=%0d q=%h need 16/15/%h", n, alive_count, v, ent(1, 460, 340));
        end
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        level     = 3'd0;
        addr      = 4'd0;
        hit_valid = 1'b0;
        hit_addr  = 4'd0;
        test_reset();
        test_load_level0();
        test_level2();
        test_hit();
        test_clear_all();
        test_hit_vs_load();
        test_rst_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
